// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FP issue controller: FSM encoding, op codes,
// exception flag positions and the canonical quiet NaN.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [4:0] OP_FADD  = 5'b00000;
    localparam logic [4:0] OP_FSUB  = 5'b00001;
    localparam logic [4:0] OP_FMUL  = 5'b00010;
    localparam logic [4:0] OP_FDIV  = 5'b00011;
    localparam logic [4:0] OP_FSQRT = 5'b01011;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
    localparam logic [4:0]  WDOG_FLAGS = 5'b10000;

    // A clear arriving with a commit keeps only the committing op's flags.
    function automatic logic [4:0] fflags_next(
        input logic [4:0] cur,
        input logic [4:0] resp,
        input logic       commit,
        input logic       clr
    );
        logic [4:0] nxt;
        if (commit && clr) begin
            nxt = resp;
        end else if (commit) begin
            nxt = cur | resp;
        end else if (clr) begin
            nxt = 5'b00000;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fpu_ctrl_wdog.sv
// EXEC-phase watchdog: counts cycles since issue and flags expiry on the
// LIMIT-th EXEC cycle.
module fpu_ctrl_wdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic in_exec,
    output logic expire
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter, restarted on every issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (in_exec) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = in_exec && (cnt_r == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/response sequencer between the core and a multi-cycle FP unit.
// Optional EXEC watchdog is enabled by defining FPU_WDOG_EN.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int TAG_W       = 5,
    parameter int WDOG_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_rs2_lsb,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             fpu_start,
    output logic [4:0]       fpu_op,
    output logic [2:0]       fpu_rm,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_rs2_lsb,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_done,
    input  logic [4:0]       fpu_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic [4:0]       resp_flags,
    output logic [4:0]       fflags,
    input  logic             fflags_clr,
    output logic             busy,
    output logic             wdog_err
);
    state_e           state_r;
    logic [TAG_W-1:0] tag_r;
    logic             accept_s;
    logic             commit_s;
    logic             wdog_expire_s;

    assign req_ready = (state_r == ST_IDLE) && !flush;
    assign accept_s  = req_valid && req_ready;
    assign commit_s  = (state_r == ST_RESP) && resp_valid && resp_ready && !flush;

`ifdef FPU_WDOG_EN
    fpu_ctrl_wdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_s),
        .in_exec (state_r == ST_EXEC),
        .expire  (wdog_expire_s)
    );
`else
    assign wdog_expire_s = 1'b0;
`endif

    // Control FSM with all unit-facing and response outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            tag_r       <= '0;
            fpu_start   <= 1'b0;
            fpu_op      <= 5'b00000;
            fpu_rm      <= 3'b000;
            fpu_a       <= 32'h0000_0000;
            fpu_b       <= 32'h0000_0000;
            fpu_rs2_lsb <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= 32'h0000_0000;
            resp_tag    <= '0;
            resp_flags  <= 5'b00000;
            busy        <= 1'b0;
            wdog_err    <= 1'b0;
        end else begin
            wdog_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        fpu_op      <= req_op;
                        fpu_rm      <= req_rm;
                        fpu_a       <= req_a;
                        fpu_b       <= req_b;
                        fpu_rs2_lsb <= req_rs2_lsb;
                        tag_r       <= req_tag;
                        fpu_start   <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // Flush beats a same-cycle done; done beats watchdog expiry.
                    if (flush) begin
                        fpu_start <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (fpu_done) begin
                        resp_data  <= fpu_result;
                        resp_flags <= fpu_flags;
                        resp_tag   <= tag_r;
                        resp_valid <= 1'b1;
                        fpu_start  <= 1'b0;
                        state_r    <= ST_RESP;
                    end else if (wdog_expire_s) begin
                        resp_data  <= CANON_NAN;
                        resp_flags <= WDOG_FLAGS;
                        resp_tag   <= tag_r;
                        resp_valid <= 1'b1;
                        fpu_start  <= 1'b0;
                        wdog_err   <= 1'b1;
                        state_r    <= ST_RESP;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_RESP: begin
                    if (flush || resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    fpu_start  <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky exception flags, updated only by committed responses or clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags <= 5'b00000;
        end else begin
            fflags <= fflags_next(fflags, resp_flags, commit_s, fflags_clr);
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized self-checking bench for fpu_issue_ctrl with a transaction-level
// timeline model and a per-cycle compare process.
module tb_fpu_issue_ctrl;
    localparam int TAG_W = 5;
    localparam int WD    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [4:0]       req_op;
    logic [2:0]       req_rm;
    logic [31:0]      req_a, req_b;
    logic             req_rs2_lsb;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             fpu_start;
    logic [4:0]       fpu_op;
    logic [2:0]       fpu_rm;
    logic [31:0]      fpu_a, fpu_b;
    logic             fpu_rs2_lsb;
    logic [31:0]      fpu_result;
    logic             fpu_done;
    logic [4:0]       fpu_flags;
    logic             resp_valid, resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic [4:0]       resp_flags, fflags;
    logic             fflags_clr;
    logic             busy, wdog_err;

    fpu_issue_ctrl #(.TAG_W(TAG_W), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
        .req_rs2_lsb(req_rs2_lsb), .req_tag(req_tag), .flush(flush),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a),
        .fpu_b(fpu_b), .fpu_rs2_lsb(fpu_rs2_lsb), .fpu_result(fpu_result),
        .fpu_done(fpu_done), .fpu_flags(fpu_flags), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .resp_flags(resp_flags), .fflags(fflags), .fflags_clr(fflags_clr),
        .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc, cap_cyc;
    int start_cnt, valid_cnt, werr_cnt;
    logic [31:0] cap_data;
    logic [4:0]  cap_flags;
    logic [TAG_W-1:0] cap_tag;

    // expected outputs for the current cycle
    bit chk_en = 1'b0;
    bit rand_clr = 1'b0;
    logic e_ready, e_start, e_busy, e_valid, e_werr;
    logic [4:0]  e_op, e_flags, ff_m, ff_next;
    logic [2:0]  e_rm;
    logic [31:0] e_a, e_b, e_data;
    logic        e_rs2;
    logic [TAG_W-1:0] e_tag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
            chk("fpu_start", {31'd0, fpu_start}, {31'd0, e_start});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_valid});
            chk("wdog_err", {31'd0, wdog_err}, {31'd0, e_werr});
            chk("fflags", {27'd0, fflags}, {27'd0, ff_m});
            if (e_start) begin
                chk("fpu_ops", {fpu_op, fpu_rm, fpu_rs2_lsb, 23'd0},
                    {e_op, e_rm, e_rs2, 23'd0});
                chk("fpu_a", fpu_a, e_a);
                chk("fpu_b", fpu_b, e_b);
            end
            if (e_valid) begin
                chk("resp_data", resp_data, e_data);
                chk("resp_tag_flags", {22'd0, resp_tag, resp_flags}, {22'd0, e_tag, e_flags});
            end
        end
    end

    // Event counters and commit capture used by the directed checks.
    always @(negedge clk) begin
        if (fpu_start) start_cnt++;
        if (resp_valid) valid_cnt++;
        if (wdog_err) werr_cnt++;
        if (resp_valid && resp_ready && !flush) begin
            cap_data = resp_data; cap_flags = resp_flags; cap_tag = resp_tag; cap_cyc = cyc;
        end
    end

    task automatic drive_default();
        req_valid = 1'b0; flush = 1'b0; fpu_done = 1'b0; resp_ready = 1'b0;
        req_op = 5'($urandom); req_rm = 3'($urandom); req_a = $urandom; req_b = $urandom;
        req_rs2_lsb = 1'($urandom); req_tag = TAG_W'($urandom);
        fpu_result = $urandom; fpu_flags = 5'($urandom);
        fflags_clr = rand_clr && ($urandom_range(0, 7) == 0);
        e_werr = 1'b0;
    endtask

    task automatic finish_cycle(input bit commit, input logic [4:0] f);
        if (commit && fflags_clr) ff_next = f;
        else if (commit) ff_next = ff_m | f;
        else if (fflags_clr) ff_next = 5'd0;
        else ff_next = ff_m;
        @(posedge clk);
        #1;
        ff_m = ff_next;
    endtask

    task automatic idle_cycle(input bit clr);
        drive_default();
        fpu_done = 1'($urandom);
        if (clr) fflags_clr = 1'b1;
        e_ready = 1'b1; e_start = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
        finish_cycle(1'b0, 5'd0);
    endtask

    // One transaction: d = cycles until done, s = resp_ready stall cycles,
    // flush_ex/flush_rs = 1-based EXEC/RESP cycle of a flush (0 = none).
    task automatic run_tx(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int d, input int s,
                          input int flush_ex, input int flush_rs,
                          input logic [31:0] res, input logic [4:0] flg,
                          input bit clr_commit, input int gap);
        int n_ex;
        bit forced;
        bit done_flag;
        logic [2:0] rm;
        logic rs2;
        rm = 3'($urandom); rs2 = 1'($urandom);
        for (int g = 0; g < gap; g++) begin
            drive_default();
            flush = 1'($urandom);
            req_valid = flush ? 1'($urandom) : 1'b0;
            fpu_done = 1'($urandom);
            e_ready = !flush; e_start = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
            finish_cycle(1'b0, 5'd0);
        end
        drive_default();
        req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b;
        req_rs2_lsb = rs2; req_tag = tag;
        e_ready = 1'b1; e_start = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
        acc_cyc = cyc;
        finish_cycle(1'b0, 5'd0);
        n_ex = d; forced = 1'b0;
`ifdef FPU_WDOG_EN
        if (d > WD) begin n_ex = WD; forced = 1'b1; end
`endif
        e_op = op; e_rm = rm; e_a = a; e_b = b; e_rs2 = rs2;
        done_flag = 1'b0;
        for (int j = 1; j <= n_ex && !done_flag; j++) begin
            drive_default();
            e_ready = 1'b0; e_start = 1'b1; e_busy = 1'b1; e_valid = 1'b0;
            fpu_done = (j == d); fpu_result = res; fpu_flags = flg;
            if (flush_ex == j) begin flush = 1'b1; done_flag = 1'b1; end
            finish_cycle(1'b0, 5'd0);
        end
        if (done_flag) return;
        e_data = forced ? 32'h7FC0_0000 : res;
        e_flags = forced ? 5'b10000 : flg;
        e_tag = tag;
        for (int r = 0; r <= s && !done_flag; r++) begin
            drive_default();
            fpu_done = 1'($urandom);
            e_ready = 1'b0; e_start = 1'b0; e_busy = 1'b1; e_valid = 1'b1;
            e_werr = forced && (r == 0);
            resp_ready = (r == s);
            if (flush_rs == r + 1) begin flush = 1'b1; resp_ready = 1'($urandom); end
            if (clr_commit && r == s) fflags_clr = 1'b1;
            done_flag = flush || resp_ready;
            finish_cycle(resp_ready && !flush, e_flags);
        end
    endtask

    initial begin
        int d, s, fe, fr;
        logic [4:0] ff_before;
        reset = 1'b0;
        drive_default();
        fflags_clr = 1'b0;
        #3;
        chk("rst_outs", {fpu_start, resp_valid, busy, wdog_err, fflags, resp_flags, fpu_op},
            {4'b0000, 15'd0});
        chk("rst_data", resp_data | fpu_a | fpu_b, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ff_m = 5'd0;
        chk_en = 1'b1;
        idle_cycle(1'b0);

        // FADD single-cycle: 1.0 + 2.0
        run_tx(5'b00000, 32'h3F80_0000, 32'h4000_0000, 5'h15, 1, 0, 0, 0,
               32'h4040_0000, 5'b00000, 1'b0, 0);
        chk("fadd_data", cap_data, 32'h4040_0000);
        chk("fadd_tag", {27'd0, cap_tag}, 32'h15);
        chk("fadd_latency", cap_cyc - acc_cyc, 32'd2);

        // FDIV, done on the 20th EXEC cycle
        start_cnt = 0;
        run_tx(5'b00011, $urandom, $urandom, 5'h03, 20, 0, 0, 0, 32'h1234_5678, 5'd0, 1'b0, 1);
`ifdef FPU_WDOG_EN
        chk("fdiv_start_cycles", start_cnt, 32'd8);
`else
        chk("fdiv_start_cycles", start_cnt, 32'd20);
`endif

        // NX with 3-cycle backpressure, then clear concurrent with an NV commit
        idle_cycle(1'b1);
        run_tx(5'b00010, $urandom, $urandom, 5'h07, 2, 3, 0, 0, 32'hCAFE_0001, 5'b00001, 1'b0, 0);
        idle_cycle(1'b0);
        chk("fflags_nx", {27'd0, fflags}, 32'h1);
        run_tx(5'b00001, $urandom, $urandom, 5'h08, 1, 1, 0, 0, 32'hCAFE_0002, 5'b10000, 1'b1, 0);
        idle_cycle(1'b0);
        chk("fflags_clr_commit", {27'd0, fflags}, 32'h10);

        // FSQRT flushed in EXEC, then a fresh request
        valid_cnt = 0;
        run_tx(5'b01011, $urandom, $urandom, 5'h09, 6, 0, 3, 0, 32'hDEAD_BEEF, 5'b01111, 1'b0, 0);
        idle_cycle(1'b0);
        chk("flush_no_resp", valid_cnt, 32'd0);
        chk("flush_fflags", {27'd0, fflags}, 32'h10);
        run_tx(5'b00000, $urandom, $urandom, 5'h0A, 1, 0, 0, 0, 32'h0BAD_F00D, 5'd0, 1'b0, 0);
        chk("post_flush_tag", {27'd0, cap_tag}, 32'h0A);

`ifdef FPU_WDOG_EN
        werr_cnt = 0;
        run_tx(5'b00011, $urandom, $urandom, 5'h0B, 1000, 0, 0, 0, 32'h1111_1111, 5'd0, 1'b0, 0);
        chk("wdog_data", cap_data, 32'h7FC0_0000);
        chk("wdog_flags", {27'd0, cap_flags}, 32'h10);
        chk("wdog_pulses", werr_cnt, 32'd1);
`endif

        // Randomized traffic
        rand_clr = 1'b1;
        for (int t = 0; t < 60; t++) begin
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 24) : $urandom_range(1, 4);
            s = $urandom_range(0, 3);
            fe = ($urandom_range(0, 7) == 0) ? $urandom_range(1, d) : 0;
            fr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, s + 1) : 0;
            run_tx(5'($urandom), $urandom, $urandom, TAG_W'($urandom), d, s, fe, fr,
                   $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 2));
        end
        rand_clr = 1'b0;
        idle_cycle(1'b0);
`ifndef FPU_WDOG_EN
        chk("no_wdog_pulse", werr_cnt, 32'd0);
`endif

        // Reset asserted mid-EXEC
        run_tx(5'b00000, $urandom, $urandom, 5'h01, 1, 0, 0, 0, 32'h0, 5'b00100, 1'b0, 0);
        ff_before = ff_m;
        drive_default();
        req_valid = 1'b1; req_a = 32'hFFFF_FFFF;
        e_ready = 1'b1; e_start = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
        finish_cycle(1'b0, 5'd0);
        drive_default();
        chk("pre_rst_start", {31'd0, fpu_start}, 32'h1);
        chk("pre_rst_fflags", {27'd0, fflags}, {27'd0, ff_before});
        chk_en = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_ctrl", {fpu_start, resp_valid, busy, wdog_err, fflags, resp_flags},
            {4'b0000, 10'd0});
        chk("async_rst_data", resp_data | fpu_a | fpu_b | {27'd0, resp_tag}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ff_m = 5'd0;
        chk_en = 1'b1;
        idle_cycle(1'b0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'h1);
        run_tx(5'b00010, $urandom, $urandom, 5'h1F, 2, 1, 0, 0, 32'h5555_AAAA, 5'b00010, 1'b0, 0);
        idle_cycle(1'b0);
        chk("post_rst_tx", cap_data, 32'h5555_AAAA);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
